// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial LSB-first adder, one full-adder step per clock; SERIAL_ADD_OVF_EN adds ovf
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-1:0] s_cat;
  logic [CW-1:0] cnt;
  logic c, p, g, s, c_nxt, last;
  always_comb begin
    p     = a_sh[0] ^ b_sh[0];
    g     = a_sh[0] & b_sh[0];
    s     = p ^ c;
    c_nxt = g | (p & c);
    s_cat = {s, s_sh};
    last  = cnt == CW'(WIDTH - 1);
    nxt   = state == IDLE  ? (start ? SHIFT : IDLE) :
            state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy  = state != IDLE;
    done  = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      cnt     <= '0;
      c       <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        a_sh <= a_in;
        b_sh <= b_in;
        c    <= cin;
        cnt  <= '0;
        s_sh <= '0;
      end else if (state == SHIFT) begin
        c    <= c_nxt;
        s_sh <= s_cat[WIDTH-1:1];
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + CW'(1);
        if (last) begin
          sum_out <= s_cat;
          cout    <= c_nxt;
`ifdef SERIAL_ADD_OVF_EN
          ovf     <= c ^ c_nxt;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed vector table plus abort, ignored-start and back-to-back sequences
module tb_serial_add_seq;
  localparam int WIDTH = 8;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [WIDTH-1:0] a_in = 0, b_in = 0;
  logic busy, done, cout;
  logic [WIDTH-1:0] sum_out;
  logic ovf_w;
  int total = 0, bad = 0;

  serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf_w)
`endif
  );
`ifndef SERIAL_ADD_OVF_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co, ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input int glitch_at, input int rst_at,
                     input logic [7:0] es, input logic ec, input logic eo, input int ed);
    int n_done = 0, at = -1, nbusy = 0, chg = 0;
    logic [7:0] prev;
    prev = sum_out;
    @(negedge clk);
    a_in = a; b_in = b; cin = ci; start = 1;
    @(posedge clk);
    #1 start = 0; a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
    for (int n = 0; n <= WIDTH + 2; n++) begin
      @(negedge clk);
      if (n == rst_at + 1) rst = 0;
      if (n == glitch_at) begin start = 1; a_in = 8'hFF; b_in = 8'hFF; end
      else start = 0;
      if (n == rst_at) begin
        rst = 1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", cout, 0);
      end
      if (busy) nbusy++;
      if (done) begin n_done++; at = n; end
      if (n < WIDTH && (rst_at < 0 || n < rst_at) && sum_out !== prev) chg++;
    end
    chk("done_count", n_done, ed);
    chk("partial_change", chg, 0);
    chk("sum", sum_out, es);
    chk("cout", cout, ec);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", ovf_w, eo);
`else
    if (eo !== 1'b0 && eo !== 1'b1) chk("ovf_exp", eo, 0);
`endif
    if (rst_at < 0) begin
      chk("done_latency", at, WIDTH);
      chk("busy_cycles", nbusy, WIDTH + 1);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int got;
    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum_out, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf_w, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 8; i++)
      run(vecs[i].a, vecs[i].b, vecs[i].ci, -1, -1, vecs[i].s, vecs[i].co, vecs[i].ov, 1);
    run(8'h12, 8'h34, 1'b0, 3, -1, 8'h46, 1'b0, 1'b0, 1);
    run(8'h80, 8'h80, 1'b0, -1, 4, 8'h00, 1'b0, 1'b0, 0);
    run(8'h01, 8'h02, 1'b0, -1, -1, 8'h03, 1'b0, 1'b0, 1);
    @(negedge clk);
    a_in = 8'h03; b_in = 8'h04; cin = 0; start = 1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("b2b_done_seen", got, 1);
    chk("b2b_sum", sum_out, 8'h07);
    @(negedge clk);
    chk("b2b_idle_gap", busy, 0);
    @(negedge clk);
    chk("b2b_reaccept", busy, 1);
    start = 0;
    repeat (WIDTH + 2) @(negedge clk);
    chk("b2b_second_sum", sum_out, 8'h07);
    chk("b2b_end_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
